// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave with valid/ready requests, fixed LATENCY and a one-cycle response pulse.
// Optional accepted-read/write counters are enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int LAT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [LAT_W-1:0] cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wen_q;

  logic [31:0] mem [0:DEPTH-1];

  logic        accept;
  logic        commit;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_wen;
  logic        c_in_range;

  assign req_ready  = rst_n && (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_W'(LATENCY)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts WAIT cycles starting at 1; leaving WAIT when it equals LATENCY
  // puts RESP exactly LATENCY+1 cycles after the accept edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= LAT_W'(1);
    end else if (state_q == WAIT && state_d == WAIT) begin
      cnt_q <= cnt_q + LAT_W'(1);
    end else if (state_q == RESP) begin
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wen_q   <= req_wen;
    end
  end

  // With LATENCY=0 the commit edge is the accept edge, so the live request
  // is used while still in IDLE instead of the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wen   = req_wen;
    end else begin
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_wen   = wen_q;
    end
  end

  assign c_in_range = (c_addr < 32'(DEPTH));
  assign commit     = rst_n && (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk) begin
    if (commit && c_wen && c_in_range) begin
      mem[c_addr[AW-1:0]] <= c_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err <= !c_in_range;
      if (c_in_range && !c_wen) begin
        resp_rdata <= mem[c_addr[AW-1:0]];
      end else begin
        resp_rdata <= '0;
      end
    end
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (accept) begin
      if (req_wen) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synchronous data-memory slave that services the single-cycle/multi-cycle CPU's word accesses over a valid/ready request channel and returns a one-cycle response pulse.
- Replaces the zero-latency combinational data memory on the CPU's data port, so the core must tolerate real memory latency.
- Storage is an internal word array that the bench loads and dumps hierarchically.

Parameters:
- DEPTH, 1024: number of 32-bit words; valid word addresses 0..DEPTH-1.
- LATENCY, 2: wait cycles between request accept and response (0 allowed).
- LAT_W, 8: width of the internal latency counter; must hold LATENCY.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  CPU request present
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  32  word address
- req_wdata  input  32  write data
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  one-cycle response strobe
- resp_rdata  output  32  read data, valid while resp_valid=1
- resp_err  output  1  address out of range, valid while resp_valid=1
- busy  output  1  transaction in flight

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Storage: array Mem[0:DEPTH-1], 32 bits wide. It is not cleared by reset; the bench preloads it with $readmemh and reads it back hierarchically.
- FSM states: IDLE, WAIT, RESP.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, counter=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - req_ready is forced 0 while rst_n=0 and rises in the first cycle with rst_n=1.
- Accept: a request is accepted at a rising edge when req_valid=1 and req_ready=1. req_ready=1 only in IDLE.
  - Accept captures req_addr, req_wen and req_wdata.
  - req_valid while req_ready=0 is ignored; the CPU must hold the request.
- Timing, with the accept cycle = cycle 0:
  - Cycles 1..LATENCY: WAIT; busy=1, req_ready=0.
  - Cycle LATENCY+1: RESP; resp_valid=1 for exactly this cycle.
  - Cycle LATENCY+2: IDLE; req_ready=1.
  - LATENCY=0 goes IDLE to RESP directly.
  - Maximum throughput is one transaction per LATENCY+2 cycles.
- Commit point: the array read or write happens on the edge entering RESP.
  - Read: resp_rdata = Mem[addr].
  - Write: Mem[addr] <= wdata; resp_rdata = 0.
- Range check: addr >= DEPTH (any upper bit set counts) gives resp_err=1, resp_rdata=0, no array write, no wrap-around.
- Outside RESP, resp_rdata and resp_err hold their last values; consumers qualify them with resp_valid.
- busy = (state != IDLE).
- Reset mid-transaction: an abort before the commit edge means no array write and no resp_valid. An abort during RESP clears resp_valid the next cycle; the write already committed stays.
- Address is a word address; no byte lanes, no alignment check.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_cnt[31:0] and wr_cnt[31:0], counting accepted reads and writes. Out-of-range requests are included.
  - Both increment on the accept edge, wrap at 2^32, and are cleared by reset.
- Undefined: the ports and logic do not exist; the block is otherwise identical.

Test Plan (LATENCY=2, DEPTH=1024):
- Preload Mem[5]=32'hDEADBEEF; read addr 5 accepted at cycle 0 -> resp_valid=1 only in cycle 3, resp_rdata=32'hDEADBEEF, resp_err=0, req_ready=1 in cycle 4.
- Write addr 10 data 32'h12345678, then read addr 10 -> write response has resp_rdata=0, resp_err=0; read response returns 32'h12345678; Mem[10]=32'h12345678.
- Read addr 1024, then write addr 32'h0000_07D0 data 32'hFFFFFFFF -> both responses have resp_err=1, resp_rdata=0; hierarchical dump of Mem is unchanged.
- req_valid held high with 3 back-to-back reads of addrs 1,2,3 -> accepts in cycles 0,4,8; responses in cycles 3,7,11 with the preloaded values.
- Write addr 20 data 32'hA5A5A5A5 accepted, rst_n=0 during cycle 1 (WAIT) -> Mem[20] unchanged, resp_valid never asserted, busy=0, req_ready=1 in the first cycle after release.
- With DMEM_PERF_CNT_EN: 4 reads and 2 writes including one out-of-range -> rd_cnt=4, wr_cnt=2; after reset both are 0.
